// File: rtl/pe_array_ctrl_pkg.sv
// Shared definitions for the PE array controller: FSM state encoding,
// mode encodings and the phase-length derivation helpers.
package pe_array_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_FEED  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic MODE_88 = 1'b0;
    localparam logic MODE_18 = 1'b1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Cycles needed to push the systolic skew and the multiplier
    // pipeline out of the array after the last operand.
    function automatic int flush_len(input int mult_lat,
                                     input int rows,
                                     input int cols);
        return mult_lat + rows + cols - 2;
    endfunction

    // Number of result words shifted out of the drain edge.
    function automatic int drain_len(input logic mode,
                                     input int   rows,
                                     input int   cols);
        return (mode == MODE_18) ? cols : rows;
    endfunction

endpackage

// File: rtl/pe_array_ctrl_cnt.sv
// pe_ctrl_cnt: loadable down-counter with a zero flag, saturating at 0.
// Ports: clk, reset, i_load, i_load_val -> o_zero.
module pe_ctrl_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pe_array_ctrl.sv
// PE array controller: sequences CLR/FEED/FLUSH/DRAIN/DONE for one job.
// Ports: clk, reset, i_start, i_mode_in, i_k_len -> o_mode, o_reset_pre,
//   o_en_pre, o_cell_out_en_pre, o_feed_req, o_res_valid, o_res_idx,
//   o_busy, o_done.
module pe_array_ctrl
    import pe_array_ctrl_pkg::*;
#(
    parameter  int ROWS     = 8,
    parameter  int COLS     = 8,
    parameter  int MULT_LAT = 3,
    parameter  int K_W      = 16,
    localparam int MAX_RC   = max2(ROWS, COLS),
    localparam int IDX_W    = (MAX_RC > 1) ? $clog2(MAX_RC) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_mode_in,
    input  logic [K_W-1:0]   i_k_len,
    output logic             o_mode,
    output logic             o_reset_pre,
    output logic             o_en_pre,
    output logic             o_cell_out_en_pre,
    output logic             o_feed_req,
    output logic             o_res_valid,
    output logic [IDX_W-1:0] o_res_idx,
    output logic             o_busy,
    output logic             o_done
);

    localparam int FLUSH_LEN = flush_len(MULT_LAT, ROWS, COLS);
    localparam int CNT_W     = max2(K_W, $clog2(FLUSH_LEN + 1));

    localparam logic [CNT_W-1:0] FLUSH_M1 = CNT_W'(FLUSH_LEN - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_mode;
    logic [K_W-1:0]     r_klen;
    logic               r_res_valid;
    logic [IDX_W-1:0]   r_res_idx;

    logic               w_load;
    logic [CNT_W-1:0]   w_load_val;
    logic               w_zero;
    logic [CNT_W-1:0]   w_klen_m1;
    logic [CNT_W-1:0]   w_drain_m1;
    logic               w_cell_out_en;

    // Counter is loaded with (length - 1) on state entry, so a phase
    // ends on the cycle the counter reads zero; length 1 works directly.
    assign w_klen_m1  = CNT_W'(r_klen) - CNT_W'(1);
    assign w_drain_m1 = CNT_W'(drain_len(r_mode, ROWS, COLS) - 1);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_CLR;
                end
            end
            ST_CLR: begin
                w_load = 1'b1;
                if (r_klen != '0) begin
                    w_state_nxt = ST_FEED;
                    w_load_val  = w_klen_m1;
                end else begin
                    w_state_nxt = ST_DRAIN;
                    w_load_val  = w_drain_m1;
                end
            end
            ST_FEED: begin
                if (w_zero) begin
                    w_state_nxt = ST_FLUSH;
                    w_load      = 1'b1;
                    w_load_val  = FLUSH_M1;
                end
            end
            ST_FLUSH: begin
                if (w_zero) begin
                    w_state_nxt = ST_DRAIN;
                    w_load      = 1'b1;
                    w_load_val  = w_drain_m1;
                end
            end
            ST_DRAIN: begin
                if (w_zero) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    pe_ctrl_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_88;
            r_klen  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && i_start) begin
                r_mode <= i_mode_in;
                r_klen <= i_k_len;
            end
        end
    end

    assign w_cell_out_en = (r_state == ST_DRAIN);

    // Result word appears one cycle after its shift enable; the index
    // restarts whenever the valid run is broken.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_res_valid <= 1'b0;
            r_res_idx   <= '0;
        end else begin
            r_res_valid <= w_cell_out_en;
            if (r_res_valid && w_cell_out_en) begin
                r_res_idx <= r_res_idx + 1'b1;
            end else begin
                r_res_idx <= '0;
            end
        end
    end

    assign o_mode            = r_mode;
    assign o_reset_pre       = (r_state == ST_CLR);
    assign o_en_pre          = (r_state == ST_FEED) ||
                               (r_state == ST_FLUSH);
    assign o_feed_req        = (r_state == ST_FEED);
    assign o_cell_out_en_pre = w_cell_out_en;
    assign o_res_valid       = r_res_valid;
    assign o_res_idx         = r_res_idx;
    assign o_busy            = (r_state != ST_IDLE);
    assign o_done            = (r_state == ST_DONE);

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Self-checking bench: default 8x8 controller and a 4x16 controller
// driven by the same stimulus, checked against a timeline model.
module tb_pe_array_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_start;
    logic        i_mode_in;
    logic [15:0] i_k_len;

    logic       a_mode, a_rp, a_en, a_coe, a_feed, a_rv, a_busy, a_done;
    logic [2:0] a_idx;
    logic       b_mode, b_rp, b_en, b_coe, b_feed, b_rv, b_busy, b_done;
    logic [3:0] b_idx;

    always #5 clk = ~clk;

    pe_array_ctrl u_a (
        .clk(clk), .reset(reset), .i_start(i_start),
        .i_mode_in(i_mode_in), .i_k_len(i_k_len),
        .o_mode(a_mode), .o_reset_pre(a_rp), .o_en_pre(a_en),
        .o_cell_out_en_pre(a_coe), .o_feed_req(a_feed),
        .o_res_valid(a_rv), .o_res_idx(a_idx),
        .o_busy(a_busy), .o_done(a_done)
    );

    pe_array_ctrl #(
        .ROWS(4), .COLS(16), .MULT_LAT(3), .K_W(16)
    ) u_b (
        .clk(clk), .reset(reset), .i_start(i_start),
        .i_mode_in(i_mode_in), .i_k_len(i_k_len),
        .o_mode(b_mode), .o_reset_pre(b_rp), .o_en_pre(b_en),
        .o_cell_out_en_pre(b_coe), .o_feed_req(b_feed),
        .o_res_valid(b_rv), .o_res_idx(b_idx),
        .o_busy(b_busy), .o_done(b_done)
    );

    typedef struct packed {
        logic       md;
        logic       rp;
        logic       en;
        logic       coe;
        logic       feed;
        logic       rv;
        logic [7:0] idx;
        logic       busy;
        logic       done;
    } ob_t;

    ob_t ga, gb;
    assign ga = {a_mode, a_rp, a_en, a_coe, a_feed, a_rv,
                 8'(a_idx), a_busy, a_done};
    assign gb = {b_mode, b_rp, b_en, b_coe, b_feed, b_rv,
                 8'(b_idx), b_busy, b_done};

    int n_pass = 0;
    int n_tot  = 0;
    bit cmp_en = 1'b0;

    function automatic int rows_of(input int i);
        return (i == 0) ? 8 : 4;
    endfunction
    function automatic int cols_of(input int i);
        return (i == 0) ? 8 : 16;
    endfunction

    // Job timeline, cycle 1 = CLR (cycle 0 is the start cycle).
    function automatic int drain_start(input int k, input bit md,
                                       input int i);
        int fl;
        fl = 3 + rows_of(i) + cols_of(i) - 2;
        return (k == 0) ? 2 : k + fl + 2;
    endfunction
    function automatic int drain_n(input bit md, input int i);
        return md ? cols_of(i) : rows_of(i);
    endfunction
    function automatic int done_at(input int k, input bit md,
                                   input int i);
        return drain_start(k, md, i) + drain_n(md, i);
    endfunction

    function automatic ob_t model(input bit act, input int t,
                                  input int k, input bit md,
                                  input int i);
        ob_t o;
        int  fl, ds, dn;
        o    = '0;
        o.md = md;
        if (act) begin
            fl     = 3 + rows_of(i) + cols_of(i) - 2;
            ds     = drain_start(k, md, i);
            dn     = done_at(k, md, i);
            o.busy = 1'b1;
            o.rp   = (t == 1);
            o.feed = (k > 0) && (t >= 2) && (t <= k + 1);
            o.en   = (k > 0) && (t >= 2) && (t <= k + 1 + fl);
            o.coe  = (t >= ds) && (t < dn);
            o.rv   = (t > ds) && (t <= dn);
            o.idx  = o.rv ? 8'(t - ds - 1) : 8'd0;
            o.done = (t == dn);
        end
        return o;
    endfunction

    bit m_act[2];
    int m_t[2];
    int m_k[2];
    bit m_md[2];

    initial begin
        m_act = '{0, 0};
        m_t   = '{0, 0};
        m_k   = '{0, 0};
        m_md  = '{0, 0};
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_act[i] <= 1'b0;
                m_md[i]  <= 1'b0;
                m_t[i]   <= 0;
            end else if (m_act[i]) begin
                if (m_t[i] == done_at(m_k[i], m_md[i], i))
                    m_act[i] <= 1'b0;
                else
                    m_t[i] <= m_t[i] + 1;
            end else if (i_start) begin
                m_act[i] <= 1'b1;
                m_t[i]   <= 1;
                m_k[i]   <= int'(i_k_len);
                m_md[i]  <= i_mode_in;
            end
        end
    end

    always @(negedge clk) begin
        ob_t e;
        ob_t g;
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                e = model(m_act[i], m_t[i], m_k[i], m_md[i], i);
                g = (i == 0) ? ga : gb;
                n_tot++;
                if (g == e)
                    n_pass++;
                else
                    $display("FAIL cycle_model dut%0d t=%0d got=%h exp=%h",
                             i, m_t[i], g, e);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    endtask

    int s_rp[2], s_en0[2], s_en1[2], s_coe0[2], s_coe1[2];
    int s_rv0[2], s_rv1[2], s_dcyc[2], s_ndone[2], s_nfeed[2];
    int s_nen[2], s_ncoe[2], s_ovl[2], s_idx[2];

    // Starts a job in the current cycle (cycle 0) and follows it until
    // both controllers are idle again. Optional re-start / reset pulses.
    task automatic run_job(input int k, input bit m, input int rs_c,
                           input int rst_c, input int budget);
        bit  fin;
        ob_t o;
        for (int i = 0; i < 2; i++) begin
            s_rp[i] = -1; s_en0[i] = -1; s_en1[i] = -1;
            s_coe0[i] = -1; s_coe1[i] = -1; s_rv0[i] = -1;
            s_rv1[i] = -1; s_dcyc[i] = -1; s_ndone[i] = 0;
            s_nfeed[i] = 0; s_nen[i] = 0; s_ncoe[i] = 0;
            s_ovl[i] = 0; s_idx[i] = -1;
        end
        i_start   = 1'b1;
        i_k_len   = 16'(k);
        i_mode_in = m;
        fin       = 1'b0;
        for (int c = 1; c <= budget && !fin; c++) begin
            @(negedge clk);
            i_start = (c == rs_c);
            reset   = (c == rst_c);
            if (c == 3) begin
                i_mode_in = ~m;
                i_k_len   = 16'(k + 7);
            end
            for (int i = 0; i < 2; i++) begin
                o = (i == 0) ? ga : gb;
                if (o.rp && s_rp[i] < 0) s_rp[i] = c;
                if (o.en) begin
                    if (s_en0[i] < 0) s_en0[i] = c;
                    s_en1[i] = c;
                    s_nen[i]++;
                end
                if (o.coe) begin
                    if (s_coe0[i] < 0) s_coe0[i] = c;
                    s_coe1[i] = c;
                    s_ncoe[i]++;
                end
                if (o.rv) begin
                    if (s_rv0[i] < 0) s_rv0[i] = c;
                    s_rv1[i] = c;
                end
                if (o.feed) s_nfeed[i]++;
                if (o.en && o.coe) s_ovl[i]++;
                if (o.done) begin
                    s_ndone[i]++;
                    s_dcyc[i] = c;
                    s_idx[i]  = int'(o.idx);
                end
            end
            if (c > 1 && !ga.busy && !gb.busy) fin = 1'b1;
        end
        i_start = 1'b0;
        reset   = 1'b0;
        if (!fin) chk("job_timeout", 0, 1);
    endtask

    initial begin
        reset     = 1'b1;
        i_start   = 1'b0;
        i_mode_in = 1'b0;
        i_k_len   = 16'd0;
        @(negedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_busy_a", int'(a_busy), 0);
        chk("rst_mode_a", int'(a_mode), 0);
        chk("rst_rv_b",   int'(b_rv),   0);
        reset = 1'b0;
        @(negedge clk);

        run_job(4, 1'b0, -1, -1, 100);
        chk("t1_rp_a",    s_rp[0],   1);
        chk("t1_en0_a",   s_en0[0],  2);
        chk("t1_en1_a",   s_en1[0],  22);
        chk("t1_feed_a",  s_nfeed[0], 4);
        chk("t1_coe0_a",  s_coe0[0], 23);
        chk("t1_coe1_a",  s_coe1[0], 30);
        chk("t1_rv0_a",   s_rv0[0],  24);
        chk("t1_rv1_a",   s_rv1[0],  31);
        chk("t1_done_a",  s_dcyc[0], 31);
        chk("t1_idx_a",   s_idx[0],  7);
        chk("t1_ndone_a", s_ndone[0], 1);
        chk("t1_done_b",  s_dcyc[1], 31);
        chk("t1_ncoe_b",  s_ncoe[1], 4);
        chk("t1_en1_b",   s_en1[1],  26);

        run_job(0, 1'b1, -1, -1, 100);
        chk("t2_rp_a",    s_rp[0],   1);
        chk("t2_coe0_a",  s_coe0[0], 2);
        chk("t2_coe1_a",  s_coe1[0], 9);
        chk("t2_done_a",  s_dcyc[0], 10);
        chk("t2_nen_a",   s_nen[0],  0);
        chk("t2_feed_a",  s_nfeed[0], 0);
        chk("t2_coe1_b",  s_coe1[1], 17);
        chk("t2_done_b",  s_dcyc[1], 18);
        chk("t2_nen_b",   s_nen[1],  0);

        run_job(20, 1'b0, 10, -1, 200);
        chk("t3_ndone_a", s_ndone[0], 1);
        chk("t3_done_a",  s_dcyc[0], 47);
        chk("t3_ndone_b", s_ndone[1], 1);
        chk("t3_done_b",  s_dcyc[1], 47);

        run_job(4, 1'b0, -1, 25, 100);
        chk("t4_ndone_a", s_ndone[0], 0);
        chk("t4_ndone_b", s_ndone[1], 0);
        chk("t4_coe0_a",  s_coe0[0], 23);

        run_job(4, 1'b0, -1, -1, 100);
        chk("t5_done_a",  s_dcyc[0], 31);
        chk("t5_ndone_a", s_ndone[0], 1);

        run_job(1, 1'b1, -1, -1, 100);
        chk("t6_nen_b",   s_nen[1],  22);
        chk("t6_coe0_b",  s_coe0[1], 24);
        chk("t6_ncoe_b",  s_ncoe[1], 16);
        chk("t6_done_b",  s_dcyc[1], 40);
        chk("t6_ovl_b",   s_ovl[1],  0);
        chk("t6_nen_a",   s_nen[0],  18);
        chk("t6_done_a",  s_dcyc[0], 28);

        run_job(65535, 1'b0, -1, -1, 66000);
        chk("t7_feed_a",  s_nfeed[0], 65535);
        chk("t7_ndone_a", s_ndone[0], 1);
        chk("t7_done_a",  s_dcyc[0], 65562);
        chk("t7_feed_b",  s_nfeed[1], 65535);
        chk("t7_done_b",  s_dcyc[1], 65562);

        repeat (3) @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
